// File: rtl/altair_io_pkg.sv
// Shared constants for the Altair front-panel I/O path (port 0xFF sense/program).
package altair_io_pkg;
  localparam logic [7:0] PORT_SENSE = 8'hFF;
  localparam int LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'hFF;
endpackage

// File: rtl/led_envelope.sv
// One programmed-output LED: saturating attack/decay brightness level and registered PWM compare.
module led_envelope
  import altair_io_pkg::*;
#(
  parameter int ATTACK = 32,
  parameter int DECAY  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               on,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               pwm
);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W:0]   sum;
  logic               pwm_q;

  always_comb begin
    level_d = level_q;
    sum     = {1'b0, level_q} + (LEVEL_W+1)'(ATTACK);
    if (tick) begin
      // Carry out of the 9-bit sum means the add overshot full brightness.
      if (on) level_d = sum[LEVEL_W] ? LEVEL_MAX : sum[LEVEL_W-1:0];
      else    level_d = (level_q < LEVEL_W'(DECAY)) ? '0 : level_q - LEVEL_W'(DECAY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pwm_q   <= (level_q > pwm_cnt) || (level_q == LEVEL_MAX);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/programmed_output.sv
// OUT 0xFF front-panel path: latches the CPU byte, flags changes, and drives eight
// persistence-enveloped PWM LEDs from a shared prescaler and PWM counter.
module programmed_output
  import altair_io_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int ATTACK   = 32,
  parameter int DECAY    = 8,
  parameter int INVERT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       changed,
  output logic [7:0] led_pwm
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [7:0]         data_q, data_d, wr_val;
  logic               changed_q, changed_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [LEVEL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic               tick;

  // The CPU side has no handshake: every wr strobe is accepted in its own cycle.
  always_comb begin
    wr_val    = (INVERT != 0) ? ~data_in : data_in;
    data_d    = data_q;
    changed_d = 1'b0;
    if (wr) begin
      data_d    = wr_val;
      changed_d = (wr_val != data_q);
    end
    tick      = (presc_q == PRE_LAST);
    presc_d   = tick ? '0 : presc_q + PRE_W'(1);
    pwm_cnt_d = pwm_cnt_q + LEVEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      changed_q <= 1'b0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      data_q    <= data_d;
      changed_q <= changed_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Envelopes see data_q, so a tick coincident with a write uses the pre-write bit.
  for (genvar i = 0; i < 8; i++) begin : g_env
    led_envelope #(
      .ATTACK(ATTACK),
      .DECAY (DECAY)
    ) u_env (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .on     (data_q[i]),
      .pwm_cnt(pwm_cnt_q),
      .pwm    (led_pwm[i])
    );
  end

  assign data_out = data_q;
  assign changed  = changed_q;

endmodule
